// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: tracks the longest matched prefix of PATTERN,
// decodes match from the state register and keeps a saturating match counter.
module moore_seq_detector #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           in,
    input  logic                           clr_cnt,
    output logic [$clog2(WIDTH+1)-1:0]     state,
    output logic                           match,
    output logic [CNT_W-1:0]               match_cnt
);

    localparam int SW = $clog2(WIDTH + 1);

    localparam logic [SW-1:0] S_IDLE  = '0;
    localparam logic [SW-1:0] S_FIRST = SW'(1);
    localparam logic [SW-1:0] S_MATCH = SW'(WIDTH);

    logic [WIDTH-1:0] hist;
    logic [WIDTH-1:0] nh;
    logic [WIDTH-1:0] mask;
    logic [SW-1:0]    nxt;

    // The candidate length is capped at state+1, so bits older than the
    // current partial match never influence the result.
    always_comb begin
        nh   = WIDTH'({hist, in});
        mask = '0;
        nxt  = S_IDLE;
        if (OVERLAP == 0 && state == S_MATCH) begin
            nxt = (in == PATTERN[WIDTH-1]) ? S_FIRST : S_IDLE;
        end else begin
            for (int l = 1; l <= WIDTH; l++) begin
                mask = WIDTH'((32'd1 << l) - 32'd1);
                if (l <= int'(state) + 1 &&
                    (nh & mask) == ((PATTERN >> (WIDTH - l)) & mask)) begin
                    nxt = SW'(l);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            hist  <= '0;
        end else if (en) begin
            state <= nxt;
            hist  <= nh;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
        end else if (en && nxt == S_MATCH && match_cnt != '1) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    assign match = (state == S_MATCH);

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: default overlap instance, a
// non-overlapping instance and a 2-bit saturating-counter instance share stimulus.
module tb_moore_seq_detector;

    logic clk;
    logic rst;
    logic en;
    logic in;
    logic clr_cnt;

    logic [2:0] a_state;
    logic       a_match;
    logic [7:0] a_cnt;
    logic [2:0] b_state;
    logic       b_match;
    logic [7:0] b_cnt;
    logic [1:0] c_state;
    logic       c_match;
    logic [1:0] c_cnt;

    int checks = 0;
    int errors = 0;

    moore_seq_detector dut_a (
        .clk(clk), .rst(rst), .en(en), .in(in), .clr_cnt(clr_cnt),
        .state(a_state), .match(a_match), .match_cnt(a_cnt)
    );

    moore_seq_detector #(.OVERLAP(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .in(in), .clr_cnt(clr_cnt),
        .state(b_state), .match(b_match), .match_cnt(b_cnt)
    );

    moore_seq_detector #(.WIDTH(2), .PATTERN(2'b11), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .en(en), .in(in), .clr_cnt(clr_cnt),
        .state(c_state), .match(c_match), .match_cnt(c_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_a(input string tag, input int st, input int m, input int cnt);
        check({tag, " a.state"}, 32'(a_state), st);
        check({tag, " a.match"}, 32'(a_match), m);
        check({tag, " a.cnt"},   32'(a_cnt),   cnt);
    endtask

    task automatic check_b(input string tag, input int st, input int m, input int cnt);
        check({tag, " b.state"}, 32'(b_state), st);
        check({tag, " b.match"}, 32'(b_match), m);
        check({tag, " b.cnt"},   32'(b_cnt),   cnt);
    endtask

    task automatic check_c(input string tag, input int st, input int m, input int cnt);
        check({tag, " c.state"}, 32'(c_state), st);
        check({tag, " c.match"}, 32'(c_match), m);
        check({tag, " c.cnt"},   32'(c_cnt),   cnt);
    endtask

    // driver: called 1 time unit after a rising edge, returns likewise
    task automatic step(input logic b, input logic e, input logic c);
        in      = b;
        en      = e;
        clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    // asynchronous reset between edges, checked before any edge arrives
    task automatic do_reset(input string tag);
        en      = 1'b0;
        clr_cnt = 1'b0;
        rst     = 1'b1;
        #2;
        check_a({tag, " async_rst"}, 0, 0, 0);
        check_b({tag, " async_rst"}, 0, 0, 0);
        check_c({tag, " async_rst"}, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp_basic[5];
        int exp_ovl_a[7];
        int exp_ovl_b[7];
        int seq_ovl[7];
        int exp_sat[6];

        exp_basic = '{1, 2, 3, 4, 2};
        seq_ovl   = '{1, 0, 1, 1, 0, 1, 1};
        exp_ovl_a = '{1, 2, 3, 4, 2, 3, 4};
        exp_ovl_b = '{1, 2, 3, 4, 0, 1, 1};
        exp_sat   = '{1, 2, 3, 3, 3, 3};

        rst = 1'b1; en = 1'b0; in = 1'b0; clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        check_a("reset", 0, 0, 0);
        check_c("reset", 0, 0, 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // basic match 1,0,1,1,0
        step(1'b1, 1'b1, 1'b0); check_a("basic e1", exp_basic[0], 0, 0);
        step(1'b0, 1'b1, 1'b0); check_a("basic e2", exp_basic[1], 0, 0);
        step(1'b1, 1'b1, 1'b0); check_a("basic e3", exp_basic[2], 0, 0);
        step(1'b1, 1'b1, 1'b0); check_a("basic e4", exp_basic[3], 1, 1);
        step(1'b0, 1'b1, 1'b0); check_a("basic e5", exp_basic[4], 0, 1);

        do_reset("after_basic");

        // overlap vs non-overlap on 1,0,1,1,0,1,1
        for (int i = 0; i < 7; i++) begin
            step(1'(seq_ovl[i]), 1'b1, 1'b0);
            check({"ovl a.state"}, 32'(a_state), exp_ovl_a[i]);
            check({"ovl b.state"}, 32'(b_state), exp_ovl_b[i]);
            check({"ovl a.match"}, 32'(a_match), (exp_ovl_a[i] == 4) ? 1 : 0);
            check({"ovl b.match"}, 32'(b_match), (exp_ovl_b[i] == 4) ? 1 : 0);
        end
        check_a("ovl end", 4, 1, 2);
        check_b("novl end", 1, 0, 1);

        do_reset("after_ovl");

        // enable gating: 1,0 / three idle cycles with toggling in / 1,1
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0); check_a("gate pre", 2, 0, 0);
        step(1'b1, 1'b0, 1'b0); check_a("gate idle1", 2, 0, 0);
        step(1'b0, 1'b0, 1'b0); check_a("gate idle2", 2, 0, 0);
        step(1'b1, 1'b0, 1'b0); check_a("gate idle3", 2, 0, 0);
        step(1'b1, 1'b1, 1'b0); check_a("gate e3", 3, 0, 0);
        step(1'b1, 1'b1, 1'b0); check_a("gate e4", 4, 1, 1);
        step(1'b0, 1'b0, 1'b0); check_a("gate hold match", 4, 1, 1);
        step(1'b0, 1'b1, 1'b0); check_a("gate release", 2, 0, 1);

        do_reset("after_gate");

        // saturation on WIDTH=2, PATTERN=11, CNT_W=2
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check_c("sat", (i == 0) ? 1 : 2, (i == 0) ? 0 : 1, (i == 0) ? 0 : exp_sat[i - 1]);
        end
        step(1'b1, 1'b1, 1'b1); check_c("clr with match", 2, 1, 0);
        step(1'b1, 1'b1, 1'b0); check_c("count after clr", 2, 1, 1);
        step(1'b0, 1'b0, 1'b1); check_c("clr while idle", 2, 1, 0);

        do_reset("after_sat");

        // reset mid-sequence discards the partial match
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0); check_a("mid pre", 3, 0, 0);
        do_reset("mid");
        step(1'b1, 1'b1, 1'b0); check_a("mid e1", 1, 0, 0);
        step(1'b0, 1'b1, 1'b0); check_a("mid e2", 2, 0, 0);
        step(1'b1, 1'b1, 1'b0); check_a("mid e3", 3, 0, 0);
        step(1'b1, 1'b1, 1'b0); check_a("mid e4", 4, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
